clk_div_prog: RTL and testbench

//  Multi-channel programmable clock divider. Successor to the fixed divide-by-4 generator.

---
 rtl/clk_div_prog_pkg.sv | 16 +
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_prog_chan.sv | 86 ++++++++
 rtl/clk_div_prog.sv | 46 ++++
 tb/tb_clk_div_prog.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/clk_div_prog_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // Ratios below DIV_MIN cannot produce both a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // The high phase takes the extra cycle when the ratio is odd.
    function automatic int unsigned high_len(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Configuration port of clk_div_prog: one valid/ready request per ratio/enable change.
interface clk_div_prog_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_chan, cfg_div, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_div, cfg_en,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_prog_chan.sv
// One divider channel: counter, active/shadow ratio and enable, and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 4,
    parameter int DEF_EN  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_stb,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    output logic             o_pending,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_en;
    logic [DIV_W-1:0] r_div_sh;
    logic             r_en_sh;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic             w_last;
    logic             w_apply;
    logic [DIV_W-1:0] w_cnt_n;
    logic [DIV_W-1:0] w_div_n;
    logic             w_en_n;
    logic [DIV_W-1:0] w_hi_n;

    assign w_last  = (r_cnt == r_div - ONE);
    // Only swap at a period boundary, or any time the channel is idle.
    assign w_apply = r_pend && (w_last || !r_en);

    always_comb begin
        w_div_n = r_div;
        w_en_n  = r_en;
        w_cnt_n = r_cnt;
        if (w_apply) begin
            w_div_n = r_div_sh;
            w_en_n  = r_en_sh;
            w_cnt_n = r_en_sh ? '0 : (r_div_sh - ONE);
        end else if (r_en) begin
            w_cnt_n = w_last ? '0 : (r_cnt + ONE);
        end
    end

    assign w_hi_n = DIV_W'(high_len(32'(w_div_n)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= DIV_W'(DEF_DIV - 1);
            r_div    <= DIV_W'(DEF_DIV);
            r_en     <= 1'(DEF_EN);
            r_div_sh <= DIV_W'(DEF_DIV);
            r_en_sh  <= 1'(DEF_EN);
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_n;
            r_div  <= w_div_n;
            r_en   <= w_en_n;
            r_clk  <= w_en_n && (w_cnt_n < w_hi_n);
            r_tick <= w_en_n && (w_cnt_n == '0);
            if (i_load_stb) begin
                r_div_sh <= DIV_W'(clamp_div(32'(i_div)));
                r_en_sh  <= i_en;
                r_pend   <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pending = r_pend;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free run-time ratio/enable updates.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = 4,
    parameter int DEF_EN   = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    clk_div_prog_if.slave       cfg,
    output logic [CHANNELS-1:0] out_clk,
    output logic [CHANNELS-1:0] out_tick
);

    logic [CHANNELS-1:0] w_pend;
    logic [CHANNELS-1:0] w_load;
    logic                w_accept;
    logic                w_chan_ok;

    // One outstanding update at a time across all channels.
    assign cfg.cfg_ready = ~|w_pend;
    assign w_accept      = cfg.cfg_valid && cfg.cfg_ready;
    assign w_chan_ok     = (32'(cfg.cfg_chan) < CHANNELS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_load[g] = w_accept && w_chan_ok && (32'(cfg.cfg_chan) == g);

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .DEF_EN  (DEF_EN)
        ) u_chan (
            .i_clk      (sys_clk),
            .i_rst      (sys_rst),
            .i_load_stb (w_load[g]),
            .i_div      (cfg.cfg_div),
            .i_en       (cfg.cfg_en),
            .o_pending  (w_pend[g]),
            .o_clk      (out_clk[g]),
            .o_tick     (out_tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog; expected per-cycle outputs are queued and checked by a monitor.
module tb_clk_div_prog;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [1:0] out_clk;
    logic [1:0] out_tick;

    clk_div_prog_if #(.CHANNELS(2), .DIV_W(8)) cfg_if ();

    clk_div_prog #(.CHANNELS(2), .DIV_W(8), .DEF_DIV(4), .DEF_EN(1)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg      (cfg_if),
        .out_clk  (out_clk),
        .out_tick (out_tick)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0] clk;
        logic [1:0] tick;
        logic       rdy;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // {clk, tick} of one channel running ratio d, k+i cycles into its period; d==0 means disabled.
    function automatic logic [1:0] pc(input int d, input int k, input int i);
        int   p;
        logic c, t;
        if (d == 0) return 2'b00;
        p = (k + i) % d;
        c = (p < (d + 1) / 2);
        t = (p == 0);
        return {c, t};
    endfunction

    // Queue n cycles of expectations; inputs set before the call are sampled on the first edge.
    task automatic run(input int n, input int d0, input int k0, input int d1, input int k1,
                       input logic rdy, input string nm);
        for (int i = 0; i < n; i++) begin
            exp_t       e;
            logic [1:0] a, b;
            a      = pc(d0, k0, i);
            b      = pc(d1, k1, i);
            e.clk  = {b[1], a[1]};
            e.tick = {b[0], a[0]};
            e.rdy  = rdy;
            e.nm   = $sformatf("%s[%0d]", nm, i);
            q.push_back(e);
            @(posedge sys_clk); #2;
        end
    endtask

    task automatic cfg(input logic v, input logic ch, input logic [7:0] d, input logic en);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_chan  = ch;
        cfg_if.cfg_div   = d;
        cfg_if.cfg_en    = en;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, " clk"},   8'(out_clk),          8'(e.clk));
                chk({e.nm, " tick"},  8'(out_tick),         8'(e.tick));
                chk({e.nm, " ready"}, 8'(cfg_if.cfg_ready), 8'(e.rdy));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        #1 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        chk("rst clk",   8'(out_clk),          8'h0);
        chk("rst tick",  8'(out_tick),         8'h0);
        chk("rst ready", 8'(cfg_if.cfg_ready), 8'h1);
        sys_rst = 1'b0;

        // Defaults: 1,1,0,0 with ticks on edges 1,5,9.
        run(12, 4, 0, 4, 0, 1'b1, "t1");

        // ch0 -> D=5 accepted at cnt=1; applied once the D=4 period ends.
        run(1, 4, 0, 4, 0, 1'b1, "t2a");
        cfg(1'b1, 1'b0, 8'd5, 1'b1);
        run(1, 4, 1, 4, 1, 1'b0, "t2acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(2, 4, 2, 4, 2, 1'b0, "t2pend");
        run(10, 5, 0, 4, 0, 1'b1, "t2d5");

        // ch1 clamp: 0 -> 2
        cfg(1'b1, 1'b1, 8'd0, 1'b1);
        run(1, 5, 0, 4, 2, 1'b0, "t3d0acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(1, 5, 1, 4, 3, 1'b0, "t3d0pend");
        run(4, 5, 2, 2, 0, 1'b1, "t3d0");
        // 1 -> 2, accepted on the wrap edge so it waits for the following wrap
        cfg(1'b1, 1'b1, 8'd1, 1'b1);
        run(1, 5, 1, 2, 0, 1'b0, "t3d1acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(1, 5, 2, 2, 1, 1'b0, "t3d1pend");
        run(1, 5, 3, 2, 0, 1'b1, "t3d1");
        // 2 stays 2
        cfg(1'b1, 1'b1, 8'd2, 1'b1);
        run(1, 5, 4, 2, 1, 1'b0, "t3d2acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(4, 5, 0, 2, 0, 1'b1, "t3d2");
        // 255 -> 128 high / 127 low
        cfg(1'b1, 1'b1, 8'd255, 1'b1);
        run(1, 5, 4, 2, 0, 1'b0, "t3d255acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(1, 5, 0, 2, 1, 1'b0, "t3d255pend");
        run(260, 5, 1, 255, 0, 1'b1, "t3d255");

        // ch0 -> D=6, then disable at cnt=1, then re-enable.
        cfg(1'b1, 1'b0, 8'd6, 1'b1);
        run(1, 5, 1, 255, 5, 1'b0, "t4d6acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(3, 5, 2, 255, 6, 1'b0, "t4d6pend");
        run(1, 6, 0, 255, 9, 1'b1, "t4d6");
        cfg(1'b1, 1'b0, 8'd6, 1'b0);
        run(1, 6, 1, 255, 10, 1'b0, "t4offacc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(4, 6, 2, 255, 11, 1'b0, "t4offpend");
        run(5, 0, 0, 255, 15, 1'b1, "t4off");
        cfg(1'b1, 1'b0, 8'd6, 1'b1);
        run(1, 0, 0, 255, 20, 1'b0, "t4onacc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(8, 6, 0, 255, 21, 1'b1, "t4on");

        // Held cfg_valid: D=8 accepted, D=3 waits for ready, then waits for the next wrap.
        cfg(1'b1, 1'b0, 8'd8, 1'b1);
        run(1, 6, 2, 255, 29, 1'b0, "t5acc1");
        cfg(1'b1, 1'b0, 8'd3, 1'b1);
        run(3, 6, 3, 255, 30, 1'b0, "t5hold");
        run(1, 8, 0, 255, 33, 1'b1, "t5d8");
        run(1, 8, 1, 255, 34, 1'b0, "t5acc2");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(6, 8, 2, 255, 35, 1'b0, "t5pend2");
        run(9, 3, 0, 255, 41, 1'b1, "t5d3");

        // Reset mid-period with a pending ch1 update.
        cfg(1'b1, 1'b1, 8'd7, 1'b1);
        run(1, 3, 0, 255, 50, 1'b0, "t6acc");
        cfg(1'b0, 1'b0, 8'd0, 1'b0);
        run(2, 3, 1, 255, 51, 1'b0, "t6pend");
        sys_rst = 1'b1;
        #1;
        chk("t6 async clk",   8'(out_clk),          8'h0);
        chk("t6 async tick",  8'(out_tick),         8'h0);
        chk("t6 async ready", 8'(cfg_if.cfg_ready), 8'h1);
        @(posedge sys_clk); #2;
        chk("t6 held clk", 8'(out_clk), 8'h0);
        sys_rst = 1'b0;
        run(8, 4, 0, 4, 0, 1'b1, "t6post");

        chk("queue drained", 8'(q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
